// File: rtl/hog_img_resize_feeder.sv
// Nearest-neighbour resampler feeding the HOG block: reads a grayscale source
// frame from BRAM and streams a fixed IMAGE_WIDTH x IMAGE_WIDTH raster as p/p_valid.
module hog_img_resize_feeder #(
  parameter int IMAGE_SIZE  = 18495,
  parameter int IMAGE_WIDTH = 136,
  parameter int SRC_AW      = 18,
  parameter int FRAC        = 8,
  parameter int RD_LAT      = 2,
  parameter int DELAY       = 1
) (
  input  logic              aclk,
  input  logic              arest_n,
  input  logic              start,
  input  logic [9:0]        src_width,
  input  logic [9:0]        src_height,
  input  logic [15:0]       step_x,
  input  logic [15:0]       step_y,
  input  logic              hog_ready,
  output logic [SRC_AW-1:0] src_addr,
  output logic              src_en,
  input  logic [7:0]        src_dout,
  output logic [7:0]        p,
  output logic              p_valid,
  output logic              finish,
  output logic              busy
);

  localparam int ACC_W  = 18;
  localparam int PROD_W = ACC_W + 10;
  localparam int OX_W   = $clog2(IMAGE_WIDTH);
  localparam int PIX_W  = $clog2(IMAGE_SIZE + 1);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, RUN, DRAIN, FIN} state_t;

  state_t             state, state_nxt;
  logic [9:0]         width_r, height_r;
  logic [15:0]        step_x_r, step_y_r;
  logic [ACC_W-1:0]   acc_x, acc_y, acc_y_nxt, row_base, mul_p1;
  logic [ACC_W-1:0]   sx, sy_nxt;
  logic [PROD_W-1:0]  prod;
  logic [SRC_AW-1:0]  addr_nxt;
  logic [OX_W-1:0]    ox;
  logic [PIX_W-1:0]   pix_cnt;
  logic [7:0]         drain_cnt;
  logic [RD_LAT-1:0]  vld_p;
  logic [7:0]         p_hold;
  logic               row_end, last_pix;
  logic               unused_delay;

  assign unused_delay = (DELAY != 0);

  // Source coordinate of an accumulator, clamped to the last valid column/row.
  function automatic logic [ACC_W-1:0] clamp_coord(input logic [ACC_W-1:0] acc,
                                                   input logic [9:0]       lim);
    logic [ACC_W-1:0] raw, max_c;
    raw   = acc >> FRAC;
    max_c = ACC_W'(lim) - ACC_W'(1);
    return (raw > max_c) ? max_c : raw;
  endfunction

  assign row_end  = (ox == OX_W'(IMAGE_WIDTH - 1));
  assign last_pix = (pix_cnt == PIX_W'(IMAGE_SIZE));
  assign p_valid  = vld_p[RD_LAT-1];
  assign p        = p_valid ? src_dout : p_hold;

  always_comb begin
    acc_y_nxt = acc_y + ACC_W'(step_y_r);
    sx        = clamp_coord(acc_x, width_r);
    sy_nxt    = clamp_coord(acc_y_nxt, height_r);
    prod      = PROD_W'(sy_nxt) * PROD_W'(width_r);
    addr_nxt  = SRC_AW'(row_base + sx);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE:     if (start) state_nxt = WAIT_RDY;
      WAIT_RDY: begin
        busy = 1'b1;
        if (hog_ready) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_pix) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == 8'(RD_LAT)) state_nxt = FIN;
      end
      FIN: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state     <= IDLE;
      src_en    <= 1'b0;
      src_addr  <= '0;
      vld_p     <= '0;
      p_hold    <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      src_en    <= (state == RUN);
      if (state == RUN) src_addr <= addr_nxt;
      vld_p[0]  <= src_en;
      for (int i = 1; i < RD_LAT; i++) vld_p[i] <= vld_p[i-1];
      drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;
      if (p_valid) p_hold <= src_dout;
    end
  end

  // ---- p1: next row's base address, ready long before the row boundary ----
  always_ff @(posedge aclk) begin
    mul_p1 <= prod[ACC_W-1:0];
    if (state == IDLE && start) begin
      width_r  <= src_width;
      height_r <= src_height;
      step_x_r <= step_x;
      step_y_r <= step_y;
      acc_x    <= '0;
      acc_y    <= '0;
      row_base <= '0;
      ox       <= '0;
      pix_cnt  <= '0;
    end else if (state == RUN) begin
      pix_cnt <= pix_cnt + PIX_W'(1);
      if (row_end) begin
        ox       <= '0;
        acc_x    <= '0;
        acc_y    <= acc_y_nxt;
        row_base <= mul_p1;
      end else begin
        ox    <= ox + OX_W'(1);
        acc_x <= acc_x + ACC_W'(step_x_r);
      end
    end
  end

endmodule

// File: tb/tb_hog_img_resize_feeder.sv
// Randomised bench for hog_img_resize_feeder: a coordinate-level model of the
// resampler and a per-cycle compare process against the DUT stream.
module tb_hog_img_resize_feeder;

  localparam int N = 136 * 136;

  logic        aclk = 1'b0;
  logic        arest_n = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  src_width = '0, src_height = '0;
  logic [15:0] step_x = '0, step_y = '0;
  logic        hog_ready = 1'b0;
  logic [17:0] src_addr;
  logic        src_en;
  logic [7:0]  src_dout;
  logic [7:0]  p;
  logic        p_valid, finish, busy;

  hog_img_resize_feeder dut (
    .aclk(aclk), .arest_n(arest_n), .start(start),
    .src_width(src_width), .src_height(src_height),
    .step_x(step_x), .step_y(step_y), .hog_ready(hog_ready),
    .src_addr(src_addr), .src_en(src_en), .src_dout(src_dout),
    .p(p), .p_valid(p_valid), .finish(finish), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Source BRAM with a two-cycle read latency.
  logic [7:0] mem [0:262143];
  logic [7:0] rd1 = '0, rd2 = '0;
  always @(posedge aclk) begin
    if (src_en) rd1 <= mem[src_addr];
    rd2 <= rd1;
  end
  assign src_dout = rd2;

  // Reference stream of the current frame.
  int         exp_addr [N];
  logic [7:0] exp_pix  [N];

  // Control shared from stimulus to the compare process.
  int frame_id = 0, chk_on = 0, start_cyc = -10, exp_first_en = 0;
  int last_lit = 0, addr_lim = 0;
  int req_reset_chk = 0, req_gate_chk = 0, req_end_chk = 0, tmo_req = 0;

  // Owned by the compare process.
  int n_checks = 0, n_errors = 0;
  int rd_idx = 0, out_idx = 0, fin_cnt = 0, last_pv = -1, seen_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (frame_id != seen_id) begin
        seen_id = frame_id;
        rd_idx = 0; out_idx = 0; fin_cnt = 0; last_pv = -1;
      end
      if (req_reset_chk != 0)
        chk("reset_outputs", int'({src_addr, src_en, p, p_valid, finish, busy}), 0);
      if (tmo_req != 0) chk("frame_timeout", 1, 0);
      if (req_gate_chk != 0) begin
        chk("gated_src_en", int'(src_en), 0);
        chk("gated_busy", int'(busy), 1);
      end
      if (req_end_chk != 0) begin
        chk("finish_count", fin_cnt, 1);
        chk("read_count", rd_idx, N);
        chk("p_valid_count", out_idx, N);
        chk("idle_busy", int'(busy), 0);
      end
      if (chk_on == 0) begin
        chk("idle_activity", int'({src_en, p_valid, finish}), 0);
      end else begin
        if (cyc == start_cyc + 1) chk("busy_after_start", int'(busy), 1);
        if (src_en) begin
          if (rd_idx >= N) chk("extra_read", rd_idx, N - 1);
          else begin
            if (rd_idx == 0) chk("first_read_cycle", cyc, exp_first_en);
            chk("src_addr", int'(src_addr), exp_addr[rd_idx]);
            chk("addr_in_range", int'(int'(src_addr) < addr_lim), 1);
            if (rd_idx == N - 1) chk("last_addr", int'(src_addr), last_lit);
            rd_idx++;
          end
        end
        if (p_valid) begin
          if (out_idx >= N) chk("extra_p_valid", out_idx, N - 1);
          else begin
            if (out_idx > 0) chk("p_valid_gap", cyc, last_pv + 1);
            chk("p", int'(p), int'(exp_pix[out_idx]));
            chk("busy_streaming", int'(busy), 1);
            last_pv = cyc;
            out_idx++;
          end
        end else if (out_idx > 0) begin
          chk("p_hold", int'(p), int'(exp_pix[out_idx-1]));
        end
        if (finish) begin
          fin_cnt++;
          chk("finish_cycle", cyc, last_pv + 1);
          chk("finish_busy", int'(busy), 0);
          chk("finish_after_all", out_idx, N);
        end
      end
    end
  end

  // Nearest-neighbour mapping straight from the scaling rules.
  task automatic build_model(input int w, input int h, input int stx, input int sty);
    for (int oy = 0; oy < 136; oy++) begin
      for (int ox = 0; ox < 136; ox++) begin
        int sx, sy, a;
        sx = ((ox * stx) & 'h3FFFF) >> 8;
        if (sx > w - 1) sx = w - 1;
        sy = ((oy * sty) & 'h3FFFF) >> 8;
        if (sy > h - 1) sy = h - 1;
        a = (sy * w + sx) & 'h3FFFF;
        exp_addr[oy*136 + ox] = a;
        exp_pix[oy*136 + ox]  = mem[a];
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 262144; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input int w, input int h, input int stx, input int sty,
                           input bit gate, input bit rand_rdy, input int abort_at,
                           input int lit, input int lim);
    int n;
    build_model(w, h, stx, sty);
    @(posedge aclk); #1;
    frame_id++;
    chk_on     = 1;
    last_lit   = lit;
    addr_lim   = lim;
    src_width  = 10'(w);
    src_height = 10'(h);
    step_x     = 16'(stx);
    step_y     = 16'(sty);
    hog_ready  = gate ? 1'b0 : 1'b1;
    start      = 1'b1;
    start_cyc  = cyc;
    exp_first_en = cyc + 3;
    @(posedge aclk); #1;
    start      = 1'b0;
    src_width  = 10'($urandom_range(1, 512));
    src_height = 10'($urandom_range(1, 512));
    step_x     = 16'($urandom);
    step_y     = 16'($urandom);
    if (gate) begin
      req_gate_chk = 1;
      repeat (50) @(posedge aclk);
      #1;
      req_gate_chk = 0;
      hog_ready    = 1'b1;
      exp_first_en = cyc + 2;
    end
    n = 0;
    while (fin_cnt == 0 && n < 25000) begin
      @(posedge aclk); #1;
      n++;
      start = gate && (n == 3000);
      if (rand_rdy) hog_ready = 1'($urandom_range(0, 1));
      if (abort_at > 0 && rd_idx >= abort_at) break;
    end
    start     = 1'b0;
    hog_ready = 1'b1;
    if (abort_at > 0) begin
      arest_n = 1'b0;
      chk_on = 0;
      req_reset_chk = 1;
      @(negedge aclk); #1;
      req_reset_chk = 0;
      @(posedge aclk); #1;
      arest_n = 1'b1;
      return;
    end
    if (fin_cnt == 0) begin
      tmo_req = 1;
      @(negedge aclk); #1;
      tmo_req = 0;
    end
    repeat (3) @(posedge aclk);
    #1;
    req_end_chk = 1;
    @(negedge aclk); #1;
    req_end_chk = 0;
    chk_on = 0;
  endtask

  initial begin
    #3 arest_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1 req_reset_chk = 1;
    @(negedge aclk); #1;
    req_reset_chk = 0;
    @(posedge aclk); #1;
    arest_n = 1'b1;

    // Identity 136x136, src[i] = i % 251
    fill_random();
    for (int i = 0; i < N; i++) mem[i] = 8'(i % 251);
    run_frame(136, 136, 'h100, 'h100, 1'b0, 1'b0, 0, 18495, 18496);

    // 2:1 downscale of 272x272, ready gated for 50 cycles, stray start mid-frame
    fill_random();
    run_frame(272, 272, 'h200, 'h200, 1'b1, 1'b0, 0, 73710, 73711);

    // Upscale 68x100 with random hog_ready toggling during the frame
    fill_random();
    run_frame(68, 100, 'h80, 'hBC, 1'b0, 1'b1, 0, 6799, 6800);

    // Zero step: aborted by reset at pixel 5000, then a full frame
    fill_random();
    mem[0] = 8'hA5;
    run_frame(200, 150, 0, 0, 1'b0, 1'b0, 5000, 0, 1);
    run_frame(200, 150, 0, 0, 1'b0, 1'b0, 0, 0, 1);

    repeat (5) @(posedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
